block_remap_ctrl: RTL and testbench

- Second-generation controller for the block-swap subsystem. Keeps a tag table mapping NumSlots SRAM slots to the block addresses resident in them.
- Looks up NumPorts request addresses per cycle and stalls the fabric on any miss.
- Issues one swap command at a time to the block mover through a valid/ready + done handshake.
- Compared with the first generation:
  - per-entry valid bits, instead of an all-ones sentinel address;
  - address width is a parameter;
  - replacement policy is selectable (round-robin or LRU);
  - invalid slots are filled first;
  - explicit flush input;
  - a proper swap FSM that tolerates a disable or flush arriving mid-swap.

---
 rtl/croc_pkg.sv | 18 +
 rtl/block_remap_victim_sel.sv | 45 ++++
 rtl/block_remap_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_block_remap_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/croc_pkg.sv
// Shared types and default sizing for the block-swap subsystem.
package croc_pkg;

  typedef enum logic {
    REMAP_RR,
    REMAP_LRU
  } remap_policy_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } swap_state_e;

  localparam int unsigned NUM_REQ_BLOCKS     = 2;
  localparam int unsigned NUM_SRAM_ADDRESSES = 4;

endpackage

// File: rtl/block_remap_victim_sel.sv
// Combinational victim picker: empty slots first, then round-robin pointer or the oldest LRU slot.
module block_remap_victim_sel
  import croc_pkg::*;
#(
  parameter int unsigned   NumSlots = NUM_SRAM_ADDRESSES,
  parameter remap_policy_e Policy   = REMAP_RR,
  localparam int unsigned  SlotIdxW = $clog2(NumSlots)
) (
  input  logic [NumSlots-1:0]               valid_i,
  input  logic [SlotIdxW-1:0]               rr_ptr_i,
  input  logic [NumSlots-1:0][SlotIdxW-1:0] age_i,
  output logic [SlotIdxW-1:0]               victim_o
);

  logic [SlotIdxW-1:0] lru_idx;
  logic                any_invalid;
  logic [SlotIdxW-1:0] invalid_idx;

  always_comb begin
    lru_idx     = '0;
    any_invalid = 1'b0;
    invalid_idx = '0;
    // Walk downwards so the lowest-indexed empty slot wins.
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (age_i[i] == SlotIdxW'(NumSlots - 1)) begin
        lru_idx = SlotIdxW'(i);
      end
      if (!valid_i[i]) begin
        any_invalid = 1'b1;
        invalid_idx = SlotIdxW'(i);
      end
    end
  end

  always_comb begin
    if (any_invalid) begin
      victim_o = invalid_idx;
    end else if (Policy == REMAP_RR) begin
      victim_o = rr_ptr_i;
    end else begin
      victim_o = lru_idx;
    end
  end

endmodule

// File: rtl/block_remap_ctrl.sv
// Block remap controller: slot tag table, per-port lookup, and a one-at-a-time swap
// command FSM towards the block mover.
module block_remap_ctrl
  import croc_pkg::*;
#(
  parameter int unsigned   NumPorts  = NUM_REQ_BLOCKS,
  parameter int unsigned   NumSlots  = NUM_SRAM_ADDRESSES,
  parameter int unsigned   AddrWidth = 21,
  parameter remap_policy_e Policy    = REMAP_RR,
  localparam int unsigned  SlotIdxW  = $clog2(NumSlots)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               en_i,
  input  logic                               flush_i,
  input  logic [NumPorts-1:0]                req_valid_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0] req_addr_i,
  output logic [NumPorts-1:0]                hit_o,
  output logic [NumPorts-1:0][SlotIdxW-1:0]  slot_idx_o,
  output logic                               stall_o,
  output logic                               swap_valid_o,
  input  logic                               swap_ready_i,
  output logic [SlotIdxW-1:0]                swap_slot_o,
  output logic                               swap_old_valid_o,
  output logic [AddrWidth-1:0]               swap_old_addr_o,
  output logic [AddrWidth-1:0]               swap_new_addr_o,
  input  logic                               swap_done_i
);

  typedef logic [NumSlots-1:0][SlotIdxW-1:0] age_vec_t;

  swap_state_e                        state_q;
  logic [NumSlots-1:0]                valid_q, valid_d;
  logic [NumSlots-1:0][AddrWidth-1:0] tag_q;
  logic [SlotIdxW-1:0]                rr_ptr_q;
  age_vec_t                           age_q, age_d;

  logic                 swap_valid_q, swap_old_valid_q, flushed_q;
  logic [SlotIdxW-1:0]  swap_slot_q;
  logic [AddrWidth-1:0] swap_old_addr_q, swap_new_addr_q;

  logic [NumPorts-1:0]  miss_vec;
  logic                 miss_any, touch_hit, write_en;
  logic [SlotIdxW-1:0]  touch_slot, victim;
  logic [AddrWidth-1:0] miss_addr;

  // Slot s becomes age 0; everything younger than its old age ages by one.
  function automatic age_vec_t touch_age(input age_vec_t a, input logic [SlotIdxW-1:0] s);
    age_vec_t r;
    r = a;
    for (int i = 0; i < NumSlots; i++) begin
      if (a[i] < a[s]) begin
        r[i] = a[i] + 1'b1;
      end
    end
    r[s] = '0;
    return r;
  endfunction

  always_comb begin
    hit_o      = '0;
    slot_idx_o = '0;
    miss_vec   = '0;
    for (int p = 0; p < NumPorts; p++) begin
      for (int s = 0; s < NumSlots; s++) begin
        if (req_valid_i[p] && en_i && valid_q[s] && (tag_q[s] == req_addr_i[p])) begin
          hit_o[p]      = 1'b1;
          slot_idx_o[p] = SlotIdxW'(s);
        end
      end
      miss_vec[p] = req_valid_i[p] && !hit_o[p];
    end
  end

  always_comb begin
    touch_hit  = 1'b0;
    touch_slot = '0;
    miss_addr  = '0;
    for (int p = NumPorts - 1; p >= 0; p--) begin
      if (hit_o[p]) begin
        touch_hit  = 1'b1;
        touch_slot = slot_idx_o[p];
      end
      if (miss_vec[p]) begin
        miss_addr = req_addr_i[p];
      end
    end
  end

  assign miss_any = en_i && (|miss_vec);
  assign stall_o  = miss_any || ((state_q != ST_IDLE) && en_i);

  // A completed swap is dropped if the table was disabled or flushed since capture.
  assign write_en = (state_q == ST_WAIT) && swap_done_i && en_i && !flush_i && !flushed_q;

  block_remap_victim_sel #(
    .NumSlots (NumSlots),
    .Policy   (Policy)
  ) u_victim_sel (
    .valid_i  (valid_q),
    .rr_ptr_i (rr_ptr_q),
    .age_i    (age_q),
    .victim_o (victim)
  );

  always_comb begin
    valid_d = valid_q;
    if (write_en) begin
      valid_d[swap_slot_q] = 1'b1;
    end
    if (!en_i || flush_i) begin
      valid_d = '0;
    end
  end

  always_comb begin
    age_d = age_q;
    if (write_en) begin
      age_d = touch_age(age_q, swap_slot_q);
    end else if (touch_hit) begin
      age_d = touch_age(age_q, touch_slot);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      tag_q    <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        age_q[i] <= SlotIdxW'(i);
      end
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
      if (write_en) begin
        tag_q[swap_slot_q] <= swap_new_addr_q;
        rr_ptr_q           <= rr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      swap_valid_q     <= 1'b0;
      swap_slot_q      <= '0;
      swap_old_valid_q <= 1'b0;
      swap_old_addr_q  <= '0;
      swap_new_addr_q  <= '0;
      flushed_q        <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (miss_any && !flush_i) begin
            state_q          <= ST_REQ;
            swap_valid_q     <= 1'b1;
            swap_slot_q      <= victim;
            swap_old_valid_q <= valid_q[victim];
            swap_old_addr_q  <= tag_q[victim];
            swap_new_addr_q  <= miss_addr;
            flushed_q        <= 1'b0;
          end
        end
        ST_REQ: begin
          if (flush_i) begin
            flushed_q <= 1'b1;
          end
          if (swap_ready_i) begin
            state_q      <= ST_WAIT;
            swap_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (flush_i) begin
            flushed_q <= 1'b1;
          end
          if (swap_done_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          swap_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign swap_valid_o     = swap_valid_q;
  assign swap_slot_o      = swap_slot_q;
  assign swap_old_valid_o = swap_old_valid_q;
  assign swap_old_addr_o  = swap_old_addr_q;
  assign swap_new_addr_o  = swap_new_addr_q;

endmodule

// File: tb/tb_block_remap_ctrl.sv
// Directed bench for block_remap_ctrl: instance 0 uses round-robin, instance 1 uses LRU.
module tb_block_remap_ctrl;
  import croc_pkg::*;

  typedef struct packed {
    logic [1:0]  slot;
    logic        ov;
    logic [20:0] oa;
    logic [20:0] na;
  } cmd_t;

  logic clk = 1'b0;
  logic rst;
  logic              en         [2];
  logic              flush      [2];
  logic [1:0]        req_valid  [2];
  logic [1:0][20:0]  req_addr   [2];
  logic [1:0]        hit        [2];
  logic [1:0][1:0]   slot_idx   [2];
  logic              stall      [2];
  logic              swap_valid [2];
  logic              swap_ready [2];
  logic [1:0]        swap_slot  [2];
  logic              old_valid  [2];
  logic [20:0]       old_addr   [2];
  logic [20:0]       new_addr   [2];
  logic              swap_done  [2];

  int   checks = 0;
  int   errors = 0;
  cmd_t exp_q[$];
  cmd_t e;
  logic [20:0] tags [8] = '{21'h0A000, 21'h0B000, 21'h0C000, 21'h0D000,
                            21'h0E000, 21'h0F000, 21'h1A000, 21'h1B000};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    block_remap_ctrl #(
      .NumPorts  (2),
      .NumSlots  (4),
      .AddrWidth (21),
      .Policy    (remap_policy_e'(g))
    ) u_dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .en_i             (en[g]),
      .flush_i          (flush[g]),
      .req_valid_i      (req_valid[g]),
      .req_addr_i       (req_addr[g]),
      .hit_o            (hit[g]),
      .slot_idx_o       (slot_idx[g]),
      .stall_o          (stall[g]),
      .swap_valid_o     (swap_valid[g]),
      .swap_ready_i     (swap_ready[g]),
      .swap_slot_o      (swap_slot[g]),
      .swap_old_valid_o (old_valid[g]),
      .swap_old_addr_o  (old_addr[g]),
      .swap_new_addr_o  (new_addr[g]),
      .swap_done_i      (swap_done[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] s, input logic ov, input logic [20:0] oa,
                      input logic [20:0] na);
    cmd_t c;
    c.slot = s; c.ov = ov; c.oa = oa; c.na = na;
    exp_q.push_back(c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b1; flush[d] = 1'b0; req_valid[d] = '0; req_addr[d] = '0;
      swap_ready[d] = 1'b0; swap_done[d] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for a command and compare it against the scoreboard head.
  task automatic wait_cmd(input int d, output cmd_t c);
    int n;
    n = 0;
    c = '0;
    while (swap_valid[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 40) else begin
      errors++;
      $error("FAIL cmd_timeout observed=%0d expected=<40", n);
    end
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL sb_empty observed=0 expected=>0");
    end
    if (exp_q.size() > 0) c = exp_q.pop_front();
    check("stall_in_req", 32'(stall[d]), 32'd1);
    check("swap_slot", 32'(swap_slot[d]), 32'(c.slot));
    check("swap_old_valid", 32'(old_valid[d]), 32'(c.ov));
    check("swap_old_addr", 32'(old_addr[d]), 32'(c.oa));
    check("swap_new_addr", 32'(new_addr[d]), 32'(c.na));
  endtask

  task automatic accept(input int d, input cmd_t c, input int delay, input logic glitch);
    for (int i = 0; i < delay; i++) begin
      swap_done[d] = glitch && (i == 1);
      @(negedge clk);
      check("hold_valid", 32'(swap_valid[d]), 32'd1);
      check("hold_slot", 32'(swap_slot[d]), 32'(c.slot));
      check("hold_new_addr", 32'(new_addr[d]), 32'(c.na));
    end
    swap_done[d]  = 1'b0;
    swap_ready[d] = 1'b1;
    @(negedge clk);
    swap_ready[d] = 1'b0;
  endtask

  task automatic finish_swap(input int d);
    swap_done[d] = 1'b1;
    @(negedge clk);
    swap_done[d] = 1'b0;
    #1;
  endtask

  task automatic fill(input int d, input logic [20:0] a, input logic [1:0] s,
                      input logic ov, input logic [20:0] oa, input int delay, input logic glitch);
    cmd_t c;
    req_valid[d][0] = 1'b1;
    req_addr[d][0]  = a;
    push(s, ov, oa, a);
    wait_cmd(d, c);
    accept(d, c, delay, glitch);
    finish_swap(d);
    check("fill_hit", 32'(hit[d][0]), 32'd1);
    check("fill_slot_idx", 32'(slot_idx[d][0]), 32'(s));
  endtask

  task automatic touch(input int d, input logic [20:0] a, input logic [1:0] s);
    req_valid[d][0] = 1'b1;
    req_addr[d][0]  = a;
    #1;
    check("touch_hit", 32'(hit[d][0]), 32'd1);
    check("touch_slot", 32'(slot_idx[d][0]), 32'(s));
    check("touch_stall", 32'(stall[d]), 32'd0);
    @(negedge clk);
    req_valid[d][0] = 1'b0;
  endtask

  initial begin
    do_reset();
    // Reset state with no requests pending.
    check("rst_stall", 32'(stall[0]), 32'd0);
    check("rst_swap_valid", 32'(swap_valid[0]), 32'd0);
    check("rst_swap_slot", 32'(swap_slot[0]), 32'd0);
    check("rst_new_addr", 32'(new_addr[0]), 32'd0);
    check("rst_hit", 32'(hit[0]), 32'd0);

    // Single miss fills slot 0.
    req_valid[0][0] = 1'b1;
    req_addr[0][0]  = 21'h00010;
    #1;
    check("miss_stall", 32'(stall[0]), 32'd1);
    fill(0, 21'h00010, 2'd0, 1'b0, 21'h0, 0, 1'b0);
    check("t1_stall", 32'(stall[0]), 32'd0);
    req_valid[0] = '0;

    // Two ports miss together: lower port first.
    do_reset();
    req_valid[0]   = 2'b11;
    req_addr[0][0] = 21'h00100;
    req_addr[0][1] = 21'h00200;
    push(2'd0, 1'b0, 21'h0, 21'h00100);
    push(2'd1, 1'b0, 21'h0, 21'h00200);
    wait_cmd(0, e);
    accept(0, e, 0, 1'b0);
    finish_swap(0);
    check("t2_hit0", 32'(hit[0][0]), 32'd1);
    check("t2_stall_mid", 32'(stall[0]), 32'd1);
    wait_cmd(0, e);
    accept(0, e, 0, 1'b0);
    finish_swap(0);
    check("t2_hits", 32'(hit[0]), 32'd3);
    check("t2_slot1", 32'(slot_idx[0][1]), 32'd1);
    check("t2_stall_end", 32'(stall[0]), 32'd0);
    req_valid[0] = '0;

    // Round-robin replacement with pointer wrap; slow ready and stray done on E.
    do_reset();
    for (int i = 0; i < 4; i++) fill(0, tags[i], 2'(i), 1'b0, 21'h0, 0, 1'b0);
    fill(0, tags[4], 2'd0, 1'b1, tags[0], 5, 1'b1);
    fill(0, tags[5], 2'd1, 1'b1, tags[1], 0, 1'b0);
    fill(0, tags[6], 2'd2, 1'b1, tags[2], 0, 1'b0);
    fill(0, tags[7], 2'd3, 1'b1, tags[3], 0, 1'b0);
    fill(0, 21'h1C000, 2'd0, 1'b1, tags[4], 0, 1'b0);
    // Disable drops all entries and the stall.
    en[0] = 1'b0;
    #1;
    check("dis_hit", 32'(hit[0][0]), 32'd0);
    check("dis_stall", 32'(stall[0]), 32'd0);
    @(negedge clk);
    en[0] = 1'b1;
    #1;
    check("reen_hit", 32'(hit[0][0]), 32'd0);
    check("reen_stall", 32'(stall[0]), 32'd1);
    req_valid[0] = '0;

    // LRU: touch A,B,C after filling; D is the oldest.
    for (int i = 0; i < 4; i++) fill(1, tags[i], 2'(i), 1'b0, 21'h0, 0, 1'b0);
    req_valid[1] = '0;
    touch(1, tags[0], 2'd0);
    touch(1, tags[1], 2'd1);
    touch(1, tags[2], 2'd2);
    fill(1, tags[4], 2'd3, 1'b1, tags[3], 0, 1'b0);
    req_valid[1] = '0;

    // Flush during WAIT: swap completes but nothing is written.
    do_reset();
    req_valid[0][0] = 1'b1;
    req_addr[0][0]  = 21'h00300;
    push(2'd0, 1'b0, 21'h0, 21'h00300);
    wait_cmd(0, e);
    accept(0, e, 0, 1'b0);
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    finish_swap(0);
    check("flush_hit", 32'(hit[0][0]), 32'd0);
    check("flush_slot_idx", 32'(slot_idx[0][0]), 32'd0);
    check("flush_stall", 32'(stall[0]), 32'd1);
    push(2'd0, 1'b0, 21'h0, 21'h00300);
    wait_cmd(0, e);
    accept(0, e, 0, 1'b0);
    finish_swap(0);
    check("refill_hit", 32'(hit[0][0]), 32'd1);

    // Reset during WAIT returns the FSM to IDLE with cleared command.
    req_addr[0][0] = 21'h00400;
    push(2'd1, 1'b0, 21'h0, 21'h00400);
    wait_cmd(0, e);
    accept(0, e, 0, 1'b0);
    rst = 1'b1;
    req_valid[0] = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_swap_valid", 32'(swap_valid[0]), 32'd0);
    check("midrst_swap_slot", 32'(swap_slot[0]), 32'd0);
    check("midrst_new_addr", 32'(new_addr[0]), 32'd0);
    check("midrst_stall", 32'(stall[0]), 32'd0);
    req_valid[0][0] = 1'b1;
    req_addr[0][0]  = 21'h00300;
    #1;
    check("midrst_table_clear", 32'(hit[0][0]), 32'd0);
    req_valid[0] = '0;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
